stream_mux_4x1: RTL
===================

STREAM_MUX_4X1 -- requirements
Module: stream_mux_4x1

Interface
REQ-001 Parameter DATA_W, default 8, width of each channel's data beat.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  reset: synchronous, active-high.
REQ-004 in_valid  input  4  per-channel beat valid; bit k is channel k.
REQ-005 in_data  input  4*DATA_W  channel k occupies bits [k*DATA_W +: DATA_W].
REQ-006 in_last  input  4  per-channel end-of-packet flag.
REQ-007 in_ready  output  4  per-channel acceptance; at most one bit high per cycle.
REQ-008 out_valid  output  1  merged stream beat valid.
REQ-009 out_data  output  DATA_W  merged stream data.
REQ-010 out_last  output  1  in_last of the presented beat.
REQ-011 out_sel  output  2  source channel index of the presented beat.
REQ-012 out_ready  input  1  downstream acceptance.

Function
REQ-013 A beat transfers on any port in a cycle where its valid and ready are both high at the rising edge of clk.
REQ-014 The output is one register stage; a beat accepted on channel k in cycle N appears on out_* in cycle N+1, with out_sel=k.
REQ-015 The output stage is free when out_valid=0 or out_ready=1; in_ready is all-zero whenever it is not free.
REQ-016 When free, the arbiter grants exactly one requesting channel: in_ready[g]=1 only if in_valid[g]=1, and it is combinational from in_valid, pointer and lock state.
REQ-017 Round-robin: search order starts at channel (ptr+1) mod 4 and wraps; ptr updates to g on each accepted beat; ptr resets to 3, so channel 0 has first priority after reset.
REQ-018 No in_valid asserted and stage free -> in_ready=0000; out_valid drops to 0 on the next edge if out_ready=1.
REQ-019 Simultaneous out_ready=1 and a new grant -> the old beat leaves and the new beat loads in the same edge; no bubble.
REQ-020 out_valid=1 with out_ready=0 -> out_data, out_last and out_sel hold stable until accepted.
REQ-021 Beats from one channel leave in the order accepted; no beat is dropped or duplicated.

Reset
REQ-022 While rst=1 at a clock edge: out_valid=0, out_data=0, out_last=0, out_sel=0, ptr=3, lock state=UNLOCKED.
REQ-023 in_ready is 0000 during any cycle with rst=1.
REQ-024 Reset mid-packet discards the held beat and any lock; no partial-packet recovery is attempted.

Configuration
REQ-025 Macro STREAM_MUX_LAST_LOCK_EN selects packet locking.
REQ-026 With the macro defined: two-state FSM UNLOCKED/LOCKED. In UNLOCKED, a grant with in_last=0 moves the FSM to LOCKED on channel g. In LOCKED, only channel g can be granted. A beat with in_last=1 on g returns the FSM to UNLOCKED. A beat with in_last=1 in UNLOCKED stays UNLOCKED.
REQ-027 Without the macro: no FSM; arbitration per REQ-017 on every beat; in_last is passed through to out_last only.

Structure
REQ-028 Shared package stream_mux_pkg holds NUM_CH=4, SEL_W=2, and the lock-state enum (UNLOCKED, LOCKED).
REQ-029 One sub-module, rr_arbiter_4, computes the one-hot grant from req[3:0] and ptr; the top holds the output register, ptr and the FSM.

Verification
REQ-030 Single channel: in_valid=0100, data 0x5A, out_ready=1 -> in_ready=0100, next cycle out_valid=1, out_data=0x5A, out_sel=2.
REQ-031 All request, out_ready=1 continuously, after reset -> grant order 0,1,2,3,0 on consecutive cycles with no idle cycles.
REQ-032 Backpressure: out_ready=0 for 3 cycles with beat 0x11 held -> in_ready=0000 and out_* stable for those cycles; out_ready=1 -> 0x11 is accepted.
REQ-033 Lock (macro on): ch1 sends a 3-beat packet (last on beat 3) while ch0 and ch2 request -> out_sel=1,1,1, then 2. Macro off: the same stimulus interleaves 1,2,0,1,...
REQ-034 Reset mid-stream: assert rst while out_valid=1 and LOCKED -> next cycle out_valid=0 and in_ready=0000; after release, channel 0 wins first.

Source files
------------

// File: rtl/stream_mux_pkg.sv
// ----------------------------------------------------------------------------
// stream_mux_pkg
// Shared definitions for the 4-to-1 stream multiplexer slice:
//   NUM_CH       number of input channels
//   SEL_W        width of a channel index
//   lock_state_t packet-lock FSM states (UNLOCKED / LOCKED)
//   onehot4_to_idx / idx_to_onehot4  grant <-> index conversion helpers
// ----------------------------------------------------------------------------
package stream_mux_pkg;

  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } lock_state_t;

  // Convert a one-hot 4-bit grant into a channel index (zero grant -> 0).
  function automatic logic [SEL_W-1:0] onehot4_to_idx(input logic [NUM_CH-1:0] oh);
    logic [SEL_W-1:0] idx;
    case (oh)
      4'b0001: idx = 2'd0;
      4'b0010: idx = 2'd1;
      4'b0100: idx = 2'd2;
      4'b1000: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

  // Convert a channel index into a one-hot 4-bit mask.
  function automatic logic [NUM_CH-1:0] idx_to_onehot4(input logic [SEL_W-1:0] idx);
    logic [NUM_CH-1:0] oh;
    case (idx)
      2'd0:    oh = 4'b0001;
      2'd1:    oh = 4'b0010;
      2'd2:    oh = 4'b0100;
      2'd3:    oh = 4'b1000;
      default: oh = 4'b0000;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/stream_mux_4x1_rr_arbiter_4.sv
// ----------------------------------------------------------------------------
// rr_arbiter_4
// Purely combinational round-robin arbiter for four requesters.
// The search starts at channel (ptr+1) mod 4 and wraps; the first requesting
// channel found receives the one-hot grant.
// Ports:
//   req    [3:0]  request vector, bit k is channel k
//   ptr    [1:0]  last granted channel (lowest priority this cycle)
//   grant  [3:0]  one-hot grant, all-zero when req is all-zero
// ----------------------------------------------------------------------------
module rr_arbiter_4
  import stream_mux_pkg::*;
(
  input  logic [NUM_CH-1:0] req,
  input  logic [SEL_W-1:0]  ptr,
  output logic [NUM_CH-1:0] grant
);

  logic [SEL_W-1:0] w_cand;
  logic             w_found;

  // Rotating priority search beginning just after the last granted channel.
  always_comb begin
    grant   = 4'b0000;
    w_found = 1'b0;
    w_cand  = 2'd0;
    for (int i = 1; i <= NUM_CH; i++) begin
      w_cand        = ptr + SEL_W'(i);
      grant[w_cand] = (!w_found && req[w_cand]) ? 1'b1 : grant[w_cand];
      w_found       = w_found | req[w_cand];
    end
  end

endmodule

// File: rtl/stream_mux_4x1.sv
// ----------------------------------------------------------------------------
// stream_mux_4x1
// Merges four valid/ready streams into one through a single output register
// stage, arbitrating round-robin between requesting channels.
// Optional packet locking is enabled by defining STREAM_MUX_LAST_LOCK_EN: once
// a channel is granted a beat with in_last=0, only that channel is granted
// until it delivers a beat with in_last=1.
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   [3:0]         per-channel beat valid
//   in_data    [4*DATA_W-1:0] channel k at [k*DATA_W +: DATA_W]
//   in_last    [3:0]         per-channel end-of-packet
//   in_ready   [3:0]         per-channel acceptance (at most one hot)
//   out_valid / out_data / out_last / out_sel   registered merged beat
//   out_ready  downstream acceptance
// ----------------------------------------------------------------------------
module stream_mux_4x1
  import stream_mux_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        in_valid,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  input  logic [NUM_CH-1:0]        in_last,
  output logic [NUM_CH-1:0]        in_ready,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_last,
  output logic [SEL_W-1:0]         out_sel,
  input  logic                     out_ready
);

  logic              r_out_valid;
  logic [DATA_W-1:0] r_out_data;
  logic              r_out_last;
  logic [SEL_W-1:0]  r_out_sel;
  logic [SEL_W-1:0]  r_ptr;

  logic [NUM_CH-1:0] w_req;
  logic [NUM_CH-1:0] w_grant;
  logic [SEL_W-1:0]  w_gidx;
  logic [DATA_W-1:0] w_gdata;
  logic              w_glast;
  logic              w_free;
  logic              w_xfer;

  // The stage can take a new beat when empty or when its beat leaves this edge.
  assign w_free   = !r_out_valid || out_ready;
  assign w_xfer   = w_free && !rst && (w_grant != 4'b0000);
  assign in_ready = w_xfer ? w_grant : 4'b0000;
  assign w_gidx   = onehot4_to_idx(w_grant);

`ifdef STREAM_MUX_LAST_LOCK_EN
  lock_state_t r_state;
  lock_state_t w_state_nxt;

  // While locked, ptr equals the locked channel (ptr follows every accepted
  // beat and only that channel can be granted), so it doubles as the owner.
  always_comb begin
    if (r_state == LOCKED) begin
      w_req = in_valid & idx_to_onehot4(r_ptr);
    end else begin
      w_req = in_valid;
    end
  end

  // Lock FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= UNLOCKED;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Lock FSM next state: enter on a non-last beat, leave on a last beat.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      UNLOCKED: begin
        if (w_xfer && !w_glast) begin
          w_state_nxt = LOCKED;
        end else begin
          w_state_nxt = UNLOCKED;
        end
      end
      LOCKED: begin
        if (w_xfer && w_glast) begin
          w_state_nxt = UNLOCKED;
        end else begin
          w_state_nxt = LOCKED;
        end
      end
      default: w_state_nxt = UNLOCKED;
    endcase
  end
`else
  assign w_req = in_valid;
`endif

  rr_arbiter_4 u_arb (
    .req   (w_req),
    .ptr   (r_ptr),
    .grant (w_grant)
  );

  // Select the granted channel's data and last flag.
  always_comb begin
    case (w_gidx)
      2'd0:    w_gdata = in_data[0*DATA_W +: DATA_W];
      2'd1:    w_gdata = in_data[1*DATA_W +: DATA_W];
      2'd2:    w_gdata = in_data[2*DATA_W +: DATA_W];
      2'd3:    w_gdata = in_data[3*DATA_W +: DATA_W];
      default: w_gdata = {DATA_W{1'b0}};
    endcase
    w_glast = in_last[w_gidx];
  end

  // Output register stage and round-robin pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= {DATA_W{1'b0}};
      r_out_last  <= 1'b0;
      r_out_sel   <= 2'd0;
      r_ptr       <= 2'd3;
    end else if (w_xfer) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_gdata;
      r_out_last  <= w_glast;
      r_out_sel   <= w_gidx;
      r_ptr       <= w_gidx;
    end else if (w_free) begin
      // Stage emptied (or already empty) with nothing new to load.
      r_out_valid <= 1'b0;
    end else begin
      // Backpressured: hold the presented beat unchanged.
      r_out_valid <= r_out_valid;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_last  = r_out_last;
  assign out_sel   = r_out_sel;

endmodule
